// File: rtl/tape_buf_fetch.sv
// Byte server between the tape player's buffer port and an SDRAM arbiter port.
// Generates the player's rd_en slot strobe and caches one aligned line of the tape image.
module tape_buf_fetch #(
  parameter int unsigned LINE_LG2  = 3,
  parameter logic [24:0] BASE_ADDR = 25'h0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        flush_i,
  output logic        rd_en_o,
  input  logic        rd_i,
  input  logic [24:0] addr_i,
  output logic [7:0]  din_o,
  output logic        mem_req_o,
  output logic [24:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic        busy_o
);

  localparam int unsigned LineBytes = 2 ** LINE_LG2;
  localparam int unsigned TagW      = 25 - LINE_LG2;

  typedef enum logic [1:0] {StLow1, StLow2, StSense, StFill} state_e;

  state_e               state_q, state_d;
  logic [TagW-1:0]      tag_q, tag_d, req_tag_q, req_tag_d;
  logic [LINE_LG2-1:0]  req_off_q, req_off_d, off_q, off_d;
  logic                 valid_q, valid_d;
  logic                 rd_en_q, rd_en_d;
  logic                 mem_req_q, mem_req_d;
  logic                 dirty_q, dirty_d;
  logic [24:0]          mem_addr_q, mem_addr_d;
  logic [7:0]           din_q, din_d;
  logic [7:0]           line_q [LineBytes];
  logic                 line_we;

  logic [TagW-1:0]      addr_tag;
  logic [LINE_LG2-1:0]  addr_off;
  logic                 hit, ack_ok, discard, last_ack;

  assign addr_tag = addr_i[24:LINE_LG2];
  assign addr_off = addr_i[LINE_LG2-1:0];
  assign hit      = valid_q && !flush_i && (tag_q == addr_tag);
  assign ack_ok   = mem_req_q && mem_ack_i;
  // Data of a request that was in flight while flush was seen is stale.
  assign discard  = dirty_q || flush_i;
  assign last_ack = (state_q == StFill) && ack_ok && !discard && (off_q == '1);

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StLow1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLow1:  state_d = StLow2;
      StLow2:  state_d = StSense;
      StSense: state_d = !rd_i ? StLow1 : (hit ? StLow1 : StFill);
      StFill:  if (last_ack) state_d = StLow1;
      default: state_d = StLow1;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o     = (state_q == StFill);
    rd_en_o    = rd_en_q;
    din_o      = din_q;
    mem_req_o  = mem_req_q;
    mem_addr_o = mem_addr_q;
  end

  // Datapath next-state
  always_comb begin
    tag_d      = tag_q;
    req_tag_d  = req_tag_q;
    req_off_d  = req_off_q;
    off_d      = off_q;
    valid_d    = flush_i ? 1'b0 : valid_q;
    rd_en_d    = (state_d == StSense) || (state_d == StFill);
    mem_req_d  = mem_req_q;
    dirty_d    = dirty_q;
    mem_addr_d = mem_addr_q;
    din_d      = din_q;
    line_we    = 1'b0;
    case (state_q)
      StSense: begin
        if (rd_i) begin
          if (hit) begin
            din_d = line_q[addr_off];
          end else begin
            req_tag_d  = addr_tag;
            req_off_d  = addr_off;
            off_d      = '0;
            dirty_d    = 1'b0;
            mem_req_d  = !flush_i;
            mem_addr_d = BASE_ADDR + {addr_tag, {LINE_LG2{1'b0}}};
          end
        end
      end
      StFill: begin
        dirty_d = dirty_q || flush_i;
        if (ack_ok) begin
          if (discard) begin
            mem_req_d  = 1'b0;
            off_d      = '0;
            mem_addr_d = BASE_ADDR + {req_tag_q, {LINE_LG2{1'b0}}};
          end else begin
            line_we    = 1'b1;
            off_d      = off_q + 1'b1;
            mem_addr_d = mem_addr_q + 25'd1;
            if (off_q == '1) begin
              mem_req_d = 1'b0;
              valid_d   = 1'b1;
              tag_d     = req_tag_q;
              // The last byte is not yet in the line array on this edge.
              din_d     = (req_off_q == '1) ? mem_data_i : line_q[req_off_q];
            end
          end
        end else if (!mem_req_q && !flush_i) begin
          mem_req_d  = 1'b1;
          dirty_d    = 1'b0;
          off_d      = '0;
          mem_addr_d = BASE_ADDR + {req_tag_q, {LINE_LG2{1'b0}}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tag_q      <= '0;
      req_tag_q  <= '0;
      req_off_q  <= '0;
      off_q      <= '0;
      valid_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      dirty_q    <= 1'b0;
      mem_addr_q <= '0;
      din_q      <= '0;
    end else begin
      tag_q      <= tag_d;
      req_tag_q  <= req_tag_d;
      req_off_q  <= req_off_d;
      off_q      <= off_d;
      valid_q    <= valid_d;
      rd_en_q    <= rd_en_d;
      mem_req_q  <= mem_req_d;
      dirty_q    <= dirty_d;
      mem_addr_q <= mem_addr_d;
      din_q      <= din_d;
    end
  end

  // Line contents are qualified by valid_q, so no reset is needed.
  always_ff @(posedge clk_sys) begin
    if (line_we) begin
      line_q[off_q] <= mem_data_i;
    end
  end

endmodule
